seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for the 6-digit seven-segment display.

---
 rtl/seg_scan_driver_if.sv | 22 ++
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus bundle for seg_scan_driver: digit data and control in, scanned display signals out.
// master drives the data side (counter/NCO logic), slave is the scan driver.
interface seg_scan_driver_if;
  logic [23:0] i_digits;
  logic [5:0]  i_dp;
  logic        i_load;
  logic        i_lz_off;
  logic [5:0]  o_seg_enb;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic        o_frame;

  modport master (
    output i_digits, i_dp, i_load, i_lz_off,
    input  o_seg_enb, o_seg, o_seg_dp, o_frame
  );

  modport slave (
    input  i_digits, i_dp, i_load, i_lz_off,
    output o_seg_enb, o_seg, o_seg_dp, o_frame
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 6-digit seven-segment driver with per-slot blanking,
// frame-synchronous data commit and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 8333,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [23:0]   r_stage_dig;
  logic [5:0]    r_stage_dp;
  logic [23:0]   r_shadow_dig;
  logic [5:0]    r_shadow_dp;
  logic          r_pending;
  logic [5:0]    r_seg_enb;
  logic [6:0]    r_seg;
  logic          r_seg_dp;
  logic          r_frame;

  logic          w_tc;
  logic          w_boundary;
  logic          w_blank;
  logic [3:0]    w_nib;
  logic [5:0]    w_lz;
  logic [5:0]    w_seg_enb;
  logic [6:0]    w_seg;
  logic          w_seg_dp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign w_tc       = (r_presc == PW'(SCAN_DIV - 1));
  assign w_boundary = w_tc && (r_idx == 3'd5);
  assign w_blank    = (r_presc < PW'(BLANK_CYC));
  assign w_nib      = r_shadow_dig[{r_idx, 2'b00} +: 4];

  // w_lz[n]: digit n and every digit above it are zero with dp off.
  always_comb begin
    logic run;
    run = 1'b1;
    w_lz = '0;
    for (int n = 5; n >= 0; n--) begin
      run = run && (r_shadow_dig[4*n +: 4] == 4'h0) && !r_shadow_dp[n];
      w_lz[n] = run;
    end
  end

  always_comb begin
    w_seg_enb = 6'h3F;
    w_seg     = 7'h00;
    w_seg_dp  = 1'b0;
    if (!w_blank) begin
      w_seg_enb = ~(6'b000001 << r_idx);
      w_seg_dp  = r_shadow_dp[r_idx];
      if (bus.i_lz_off && (r_idx != 3'd0) && w_lz[r_idx]) begin
        w_seg = 7'h00;
      end else begin
        w_seg = hex_to_seg(w_nib);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A load in the boundary cycle bypasses staging so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_dig  <= '0;
      r_stage_dp   <= '0;
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (bus.i_load) begin
        r_stage_dig <= bus.i_digits;
        r_stage_dp  <= bus.i_dp;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (bus.i_load) begin
          r_shadow_dig <= bus.i_digits;
          r_shadow_dp  <= bus.i_dp;
        end else if (r_pending) begin
          r_shadow_dig <= r_stage_dig;
          r_shadow_dp  <= r_stage_dp;
        end
      end else if (bus.i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_enb <= 6'h3F;
      r_seg     <= '0;
      r_seg_dp  <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_seg_enb <= w_seg_enb;
      r_seg     <= w_seg;
      r_seg_dp  <= w_seg_dp;
      r_frame   <= w_boundary;
    end
  end

  assign bus.o_seg_enb = r_seg_enb;
  assign bus.o_seg     = r_seg;
  assign bus.o_seg_dp  = r_seg_dp;
  assign bus.o_frame   = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a 10-cycle slot and 2 blank cycles.
module tb_seg_scan_driver;
  localparam int unsigned SCAN_DIV  = 10;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          FRAME_CYC = 6 * SCAN_DIV;

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_driver_if bus();

  seg_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  slot_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] cur_dig = '0;
  logic [5:0]  cur_dp = '0;
  bit          pushed_next = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected frame for the given data under the current leading-zero mode.
  task automatic push_frame(input logic [23:0] dig, input logic [5:0] dp);
    slot_t s [6];
    bit sup;
    logic [3:0] nib;
    sup = bus.i_lz_off;
    for (int n = 5; n >= 0; n--) begin
      nib = dig[4*n +: 4];
      s[n].enb = ~(6'b000001 << n);
      s[n].dp  = dp[n];
      if (sup && n != 0 && nib == 4'h0 && !dp[n]) begin
        s[n].seg = 7'h00;
      end else begin
        sup = 0;
        s[n].seg = ref_seg(nib);
      end
    end
    for (int n = 0; n < 6; n++) sb_q.push_back(s[n]);
    cur_dig = dig;
    cur_dp  = dp;
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] p);
    bus.i_digits = d;
    bus.i_dp     = p;
    bus.i_load   = 1'b1;
    if (pushed_next) repeat (6) sb_q.delete(sb_q.size() - 1);
    push_frame(d, p);
    pushed_next = 1;
  endtask

  // Walks one frame starting just after a frame anchor; optional loads at cycles k1/k2.
  task automatic run_frame(input int k1, input logic [23:0] d1, input logic [5:0] p1,
                           input int k2, input logic [23:0] d2, input logic [5:0] p2);
    slot_t e;
    logic [5:0] x_enb;
    logic [6:0] x_seg;
    logic x_dp, x_frame;
    int pos;
    e = '0;
    for (int k = 1; k <= FRAME_CYC; k++) begin
      @(negedge clk);
      pos = (k - 1) % int'(SCAN_DIV);
      if (pos == 0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty k=%0d: got 0 entries, required >= 1", k);
        end else begin
          e = sb_q.pop_front();
        end
      end
      x_enb   = (pos < int'(BLANK_CYC)) ? 6'h3F : e.enb;
      x_seg   = (pos < int'(BLANK_CYC)) ? 7'h00 : e.seg;
      x_dp    = (pos < int'(BLANK_CYC)) ? 1'b0  : e.dp;
      x_frame = (k == FRAME_CYC);
      checks += 4;
      if (bus.o_seg_enb !== x_enb) begin
        errors++;
        $display("FAIL seg_enb k=%0d: got %b required %b", k, bus.o_seg_enb, x_enb);
      end
      if (bus.o_seg !== x_seg) begin
        errors++;
        $display("FAIL seg k=%0d: got %h required %h", k, bus.o_seg, x_seg);
      end
      if (bus.o_seg_dp !== x_dp) begin
        errors++;
        $display("FAIL seg_dp k=%0d: got %b required %b", k, bus.o_seg_dp, x_dp);
      end
      if (bus.o_frame !== x_frame) begin
        errors++;
        $display("FAIL frame k=%0d: got %b required %b", k, bus.o_frame, x_frame);
      end
      bus.i_load = 1'b0;
      if (k == k1) do_load(d1, p1);
      else if (k == k2) do_load(d2, p2);
    end
    if (!pushed_next) push_frame(cur_dig, cur_dp);
    pushed_next = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 4;
    if (bus.o_seg_enb !== 6'h3F) begin
      errors++; $display("FAIL %s_enb: got %b required 111111", tag, bus.o_seg_enb);
    end
    if (bus.o_seg !== 7'h00) begin
      errors++; $display("FAIL %s_seg: got %h required 00", tag, bus.o_seg);
    end
    if (bus.o_seg_dp !== 1'b0) begin
      errors++; $display("FAIL %s_dp: got %b required 0", tag, bus.o_seg_dp);
    end
    if (bus.o_frame !== 1'b0) begin
      errors++; $display("FAIL %s_frame: got %b required 0", tag, bus.o_frame);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_digits = '0; bus.i_dp = '0; bus.i_load = 1'b0; bus.i_lz_off = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    push_frame(24'h0, 6'h0);
    run_frame(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_mid_frame();
    run_frame(23, 24'h123456, 6'b000100, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(10, 24'h111111, 6'h0, 35, 24'h222222, 6'h0);
    run_frame(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_lz();
    bus.i_lz_off = 1'b1;
    run_frame(5, 24'h000705, 6'h0, 0, 0, 0);
    run_frame(40, 24'h000000, 6'b000100, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_boundary_load();
    run_frame(FRAME_CYC - 1, 24'hABCDEF, 6'b100001, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_scan();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.i_load = 1'b0;
      if (k == 5) do_load(24'h999999, 6'h3F);
    end
    bus.i_load = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sb_q.delete();
    pushed_next = 0;
    push_frame(24'h0, 6'h0);
    run_frame(0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_mid_frame();
    test_back_to_back();
    test_lz();
    test_boundary_load();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
